// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: turns the register-file pause code into PC, IF/ID and ID/EX
// enables, with branch flush, whole-pipe hold, stall statistics and a sticky hazard-timeout flag.
module stall_ctrl #(
    parameter int MAX_STALL = 3,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pause,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             flush,
    input  logic             ext_hold,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             stall_active,
    output logic             hazard_err,
    output logic [CNT_W-1:0] stall_cycles
);
    // state  | meaning
    // RUN_S  | normal flow or flush last cycle; stall_len is zero
    // HAZ_S  | last cycle was a hazard stall; stall_len counts the run
    // HOLD_S | last cycle was an external hold; stall_len frozen
    typedef enum logic [1:0] {RUN_S, HAZ_S, HOLD_S} state_t;

    localparam int                LEN_W   = $clog2(MAX_STALL + 1);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_STALL);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   stall_len_q, stall_len_d;
    logic               flush_pend_q, flush_pend_d;
    logic               hazard_err_q, hazard_err_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic               hz;
    logic               fl;
    logic [LEN_W-1:0]   len_base;

    always_comb begin
        hz             = (pause[0] & id_uses_rs) | (pause[1] & id_uses_rt);
        fl             = flush | flush_pend_q;
        pc_we          = 1'b0;
        ifid_we        = 1'b0;
        ifid_flush     = 1'b0;
        idex_we        = 1'b0;
        idex_bubble    = 1'b0;
        stall_active   = 1'b0;
        state_d        = RUN_S;
        stall_len_d    = stall_len_q;
        flush_pend_d   = flush_pend_q;
        hazard_err_d   = hazard_err_q;
        stall_cycles_d = stall_cycles_q;
        // A hazard following a non-stall cycle always starts a fresh run
        len_base       = (state_q == RUN_S) ? '0 : stall_len_q;

        if (!rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ext_hold) begin
            state_d = HOLD_S;
            if (flush) flush_pend_d = 1'b1;
        end else if (fl) begin
            pc_we        = 1'b1;
            ifid_flush   = 1'b1;
            idex_we      = 1'b1;
            idex_bubble  = 1'b1;
            flush_pend_d = 1'b0;
            stall_len_d  = '0;
        end else if (hz) begin
            idex_we        = 1'b1;
            idex_bubble    = 1'b1;
            stall_active   = 1'b1;
            state_d        = HAZ_S;
            stall_cycles_d = stall_cycles_q + 1'b1;
            if (len_base == MAX_LEN) begin
                hazard_err_d = 1'b1;
                stall_len_d  = len_base;
            end else begin
                stall_len_d  = len_base + 1'b1;
            end
        end else begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            idex_we     = 1'b1;
            stall_len_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= RUN_S;
            stall_len_q    <= '0;
            flush_pend_q   <= 1'b0;
            hazard_err_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_len_q    <= stall_len_d;
            flush_pend_q   <= flush_pend_d;
            hazard_err_q   <= hazard_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hazard_err   = hazard_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed scenarios plus random traffic, checked cycle by cycle against a
// rule-level reference model (run length, pending flush, sticky error, wrapping counter).
module tb_stall_ctrl;
    localparam int MAX_STALL = 3;

    logic        clk = 1'b0;
    logic        rst, id_uses_rs, id_uses_rt, flush, ext_hold;
    logic [1:0]  pause;
    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, stall_active, hazard_err;
    logic [31:0] stall_cycles;

    int n_err = 0;
    int n_chk = 0;

    int          m_len  = 0;
    bit          m_pend = 1'b0;
    bit          m_err  = 1'b0;
    logic [31:0] m_cnt  = '0;

    always #5 clk = ~clk;

    stall_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pause(pause), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .flush(flush), .ext_hold(ext_hold), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_bubble(idex_bubble),
        .stall_active(stall_active), .hazard_err(hazard_err), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step(input bit r, input logic [1:0] p, input bit urs, input bit urt,
                        input bit fls, input bit hd);
        bit hz, fl;
        bit e_pc, e_ifid, e_ifl, e_idex, e_bub, e_stall;
        @(negedge clk);
        rst = r; pause = p; id_uses_rs = urs; id_uses_rt = urt; flush = fls; ext_hold = hd;
        #1;
        hz = (p[0] && urs) || (p[1] && urt);
        fl = fls || m_pend;
        {e_pc, e_ifid, e_ifl, e_idex, e_bub, e_stall} = 6'b000000;
        if (!r)          {e_ifl, e_bub} = 2'b11;
        else if (hd)     ;
        else if (fl)     {e_pc, e_ifl, e_idex, e_bub} = 4'b1111;
        else if (hz)     {e_idex, e_bub, e_stall} = 3'b111;
        else             {e_pc, e_ifid, e_idex} = 3'b111;
        check("pc_we",        64'(pc_we),        64'(e_pc));
        check("ifid_we",      64'(ifid_we),      64'(e_ifid));
        check("ifid_flush",   64'(ifid_flush),   64'(e_ifl));
        check("idex_we",      64'(idex_we),      64'(e_idex));
        check("idex_bubble",  64'(idex_bubble),  64'(e_bub));
        check("stall_active", 64'(stall_active), 64'(e_stall));
        check("hazard_err",   64'(hazard_err),   64'(m_err));
        check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
        @(posedge clk);
        if (!r) begin
            m_len = 0; m_pend = 0; m_err = 0; m_cnt = '0;
        end else if (hd) begin
            if (fls) m_pend = 1;
        end else if (fl) begin
            m_pend = 0; m_len = 0;
        end else if (hz) begin
            m_cnt = m_cnt + 1;
            if (m_len == MAX_STALL) m_err = 1;
            else                    m_len = m_len + 1;
        end else begin
            m_len = 0;
        end
    endtask

    initial begin
        rst = 0; pause = 2'b00; id_uses_rs = 0; id_uses_rt = 0; flush = 0; ext_hold = 0;

        step(0, 2'b00, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0);
        check("post_reset_cnt", 64'(stall_cycles), 64'd0);

        // three RS stall cycles, then release
        repeat (3) step(1, 2'b01, 1, 0, 0, 0);
        step(1, 2'b00, 1, 0, 0, 0);
        check("three_stalls_cnt", 64'(stall_cycles), 64'd3);
        check("three_stalls_err", 64'(hazard_err), 64'd0);

        // pause on an unused operand is ignored
        step(1, 2'b10, 1, 0, 0, 0);
        check("unused_rt_pc_we", 64'(pc_we), 64'd1);

        // five-cycle hazard overruns MAX_STALL
        repeat (5) step(1, 2'b11, 1, 1, 0, 0);
        step(1, 2'b00, 1, 1, 0, 0);
        check("timeout_err", 64'(hazard_err), 64'd1);
        step(1, 2'b00, 1, 1, 0, 0);

        // flush beats a concurrent hazard
        step(1, 2'b11, 1, 1, 1, 0);
        step(1, 2'b00, 0, 0, 0, 0);
        check("flush_haz_cnt", 64'(stall_cycles), 64'd8);

        // hold with a flush pulse in its second cycle; flush lands after the hold
        step(1, 2'b00, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 1, 1);
        step(1, 2'b00, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0);

        // hazard straddling a hold keeps its run length
        repeat (2) step(1, 2'b01, 1, 0, 0, 0);
        step(1, 2'b01, 1, 0, 0, 1);
        repeat (2) step(1, 2'b01, 1, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0);

        // counter wrap
        @(posedge clk);
        #2 force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cycles_q;
        m_cnt = 32'hFFFF_FFFF;
        step(1, 2'b10, 0, 1, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0);
        check("wrap_cnt", 64'(stall_cycles), 64'd0);

        // reset in the middle of a stall and a pending flush
        step(1, 2'b11, 1, 1, 0, 0);
        step(1, 2'b00, 0, 0, 1, 1);
        step(0, 2'b11, 1, 1, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0);
        check("reset_clears_err", 64'(hazard_err), 64'd0);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] p;
            p = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 49) != 0), p, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
